btn_move_ctrl: RTL



---
 rtl/game_pkg.sv | 15 +
 rtl/btn_debounce.sv | 62 ++++++
 rtl/btn_move_ctrl.sv | 138 +++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared 2048 game definitions: move codes (fixing the button bit order)
// and tick divider defaults for synthesis and simulation.
package game_pkg;

  typedef enum logic [1:0] {
    MOVE_UP    = 2'd0,
    MOVE_DOWN  = 2'd1,
    MOVE_LEFT  = 2'd2,
    MOVE_RIGHT = 2'd3
  } move_e;

  localparam int TICK_DIV_SYN = 500000;
  localparam int TICK_DIV_SIM = 4;

endpackage

// File: rtl/btn_debounce.sv
// One button channel: two-flop synchroniser, tick-qualified debounce counter,
// debounced level, a one-cycle press pulse and a level-change pulse.
module btn_debounce
  import game_pkg::*;
#(
  parameter int DB_TICKS = 4
) (
  input  logic Clk,
  input  logic Reset,
  input  logic btn_raw,
  input  logic tick,
  output logic level,
  output logic press,
  output logic change
);

  localparam int CNT_W = (DB_TICKS < 2) ? 1 : $clog2(DB_TICKS);

  logic             sync1_q, sync2_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             level_prev_q;

  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    if (tick) begin
      if (sync2_q != level_q) begin
        // The DB_TICKS-th consecutive disagreeing sample flips the level.
        if (cnt_q == CNT_W'(DB_TICKS - 1)) begin
          level_d = ~level_q;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end else begin
        cnt_d = '0;
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      cnt_q        <= '0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
    end else begin
      sync1_q      <= btn_raw;
      sync2_q      <= sync1_q;
      cnt_q        <= cnt_d;
      level_q      <= level_d;
      level_prev_q <= level_q;
    end
  end

  assign level  = level_q;
  assign press  = level_q & ~level_prev_q;
  assign change = level_q ^ level_prev_q;

endmodule

// File: rtl/btn_move_ctrl.sv
// Button front end for the 2048 game: debounced channels, optional auto-repeat,
// per-channel pending bits and a valid/ready move slot with overrun flag.
module btn_move_ctrl
  import game_pkg::*;
#(
  parameter int N_BTN        = 4,
  parameter int TICK_DIV     = TICK_DIV_SYN,
  parameter int DB_TICKS     = 4,
  parameter int REPEAT_EN    = 1,
  parameter int REPEAT_DELAY = 64,
  parameter int REPEAT_TICKS = 16,
  localparam int CODE_W      = $clog2(N_BTN)
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [N_BTN-1:0]  btn_raw,
  output logic              move_valid,
  output logic [CODE_W-1:0] move_code,
  input  logic              move_ready,
  output logic [N_BTN-1:0]  btn_level,
  output logic              overrun,
  input  logic              clr_overrun
);

  localparam int TICK_W = $clog2(TICK_DIV);

  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic              tick;

  always_comb begin
    tick       = (tick_cnt_q == TICK_W'(TICK_DIV - 1));
    tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_W'(1);
  end

  logic [N_BTN-1:0] press_vec, change_vec;

  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    btn_debounce #(.DB_TICKS(DB_TICKS)) u_db (
      .Clk    (Clk),
      .Reset  (Reset),
      .btn_raw(btn_raw[g]),
      .tick   (tick),
      .level  (btn_level[g]),
      .press  (press_vec[g]),
      .change (change_vec[g])
    );
  end

  logic [N_BTN-1:0] rpt_vec;

  if (REPEAT_EN != 0) begin : g_rpt
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_TICKS) ? REPEAT_DELAY : REPEAT_TICKS;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);

    logic              rpt_on_q, rpt_on_d;
    logic [CODE_W-1:0] rpt_ch_q, rpt_ch_d;
    logic [RPT_W-1:0]  rpt_cnt_q, rpt_cnt_d;
    logic              single_high, fire;
    logic [CODE_W-1:0] press_idx;

    always_comb begin
      single_high = (btn_level != '0) && ((btn_level & (btn_level - N_BTN'(1))) == '0);
      press_idx   = '0;
      for (int i = N_BTN - 1; i >= 0; i--) begin
        if (press_vec[i]) press_idx = CODE_W'(i);
      end
      fire      = rpt_on_q & tick & (rpt_cnt_q == RPT_W'(1));
      rpt_on_d  = rpt_on_q;
      rpt_ch_d  = rpt_ch_q;
      rpt_cnt_d = rpt_cnt_q;
      // Arming has priority; any other level change (incl. releases) cancels.
      if ((press_vec != '0) && single_high) begin
        rpt_on_d  = 1'b1;
        rpt_ch_d  = press_idx;
        rpt_cnt_d = RPT_W'(REPEAT_DELAY);
      end else if (change_vec != '0) begin
        rpt_on_d = 1'b0;
      end else if (rpt_on_q && tick) begin
        rpt_cnt_d = fire ? RPT_W'(REPEAT_TICKS) : rpt_cnt_q - RPT_W'(1);
      end
      rpt_vec = fire ? (N_BTN'(1) << rpt_ch_q) : '0;
    end

    always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
        rpt_on_q  <= 1'b0;
        rpt_ch_q  <= '0;
        rpt_cnt_q <= '0;
      end else begin
        rpt_on_q  <= rpt_on_d;
        rpt_ch_q  <= rpt_ch_d;
        rpt_cnt_q <= rpt_cnt_d;
      end
    end
  end else begin : g_no_rpt
    assign rpt_vec = '0;
  end

  logic [N_BTN-1:0]  pend_q, pend_d, ev, sel_vec;
  logic              valid_q, valid_d, ovr_q, ovr_d, load;
  logic [CODE_W-1:0] code_q, code_d, sel;

  always_comb begin
    load = (!valid_q || move_ready) && (pend_q != '0);
    sel  = '0;
    for (int i = N_BTN - 1; i >= 0; i--) begin
      if (pend_q[i]) sel = CODE_W'(i);
    end
    sel_vec = load ? (N_BTN'(1) << sel) : '0;
    ev      = press_vec | rpt_vec;
    // A new event on the channel being loaded re-pends it without overrun.
    pend_d  = (pend_q & ~sel_vec) | ev;
    ovr_d   = (|(ev & pend_q & ~sel_vec)) ? 1'b1 : (clr_overrun ? 1'b0 : ovr_q);
    valid_d = load ? 1'b1 : (move_ready ? 1'b0 : valid_q);
    code_d  = load ? sel : code_q;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      tick_cnt_q <= '0;
      pend_q     <= '0;
      valid_q    <= 1'b0;
      code_q     <= '0;
      ovr_q      <= 1'b0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      pend_q     <= pend_d;
      valid_q    <= valid_d;
      code_q     <= code_d;
      ovr_q      <= ovr_d;
    end
  end

  assign move_valid = valid_q;
  assign move_code  = code_q;
  assign overrun    = ovr_q;

endmodule
